// File: rtl/i2c_target_responder.sv
// i2c_target_responder
//   I2C target that answers one 7-bit address. It decodes START/STOP from
//   oversampled SCL/SDA, ACKs or NACKs, and moves data bytes between the bus
//   and two byte FIFOs on the system side.
//   Ports:
//     clk_i, rst_i                  system clock, synchronous active-high reset
//     scl_i, sda_i                  asynchronous bus inputs
//     sda_oe_o                      1 pulls SDA low (open drain)
//     rx_data_o/rx_valid_o/rx_ready_i   received write bytes (FWFT)
//     tx_data_i/tx_valid_i/tx_ready_o   bytes returned on bus reads
//     busy_o                        addressed transaction in progress
//     ovf_o, urf_o                  sticky RX overflow / TX underflow

// Byte FIFO, first-word-fall-through, binary pointers with a wrap bit.
module i2c_target_responder_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic [7:0] data_o,
    output logic       empty_o,
    output logic       full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic [7:0]  mem_q [DEPTH];
    logic [7:0]  mem_d [DEPTH];
    logic        bypass, do_push, do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    // Push and pop on an empty FIFO hand the incoming byte straight through.
    assign bypass  = push_i & pop_i & empty_o;
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & ~bypass & (~full_o | do_pop);
    assign data_o  = bypass ? data_i : (empty_o ? 8'h00 : mem_q[rd_q[AW-1:0]]);

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (do_push) begin
            mem_d[wr_q[AW-1:0]] = data_i;
            wr_d = wr_q + {{AW{1'b0}}, 1'b1};
        end
        if (do_pop) rd_d = rd_q + {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            mem_q <= '{default: 8'h00};
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end
endmodule

module i2c_target_responder #(
    parameter logic [6:0] ADDR       = 7'h22,
    parameter int         FIFO_DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       busy_o,
    output logic       ovf_o,
    output logic       urf_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
    } state_t;

    // 2-FF synchronizer plus one history stage, preset to the idle bus level.
    logic scl_s1_q, scl_s2_q, scl_h_q, sda_s1_q, sda_s2_q, sda_h_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            {scl_s1_q, scl_s2_q, scl_h_q} <= 3'b111;
            {sda_s1_q, sda_s2_q, sda_h_q} <= 3'b111;
        end else begin
            {scl_s1_q, scl_s2_q, scl_h_q} <= {scl_i, scl_s1_q, scl_s2_q};
            {sda_s1_q, sda_s2_q, sda_h_q} <= {sda_i, sda_s1_q, sda_s2_q};
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_s2_q & ~scl_h_q;
    assign scl_fall  = ~scl_s2_q & scl_h_q;
    assign start_det = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
    assign stop_det  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;

    // FIFOs
    logic       rx_push, rx_pop, rx_empty, rx_full;
    logic       tx_push, tx_pop, tx_empty, tx_full, tx_avail;
    logic [7:0] tx_dout, sh_q, sh_d, rd_byte, addr_byte;

    assign rx_valid_o = ~rx_empty;
    assign rx_pop     = rx_valid_o & rx_ready_i;
    assign tx_ready_o = ~tx_full;
    assign tx_push    = tx_valid_i & tx_ready_o;
    assign tx_avail   = ~tx_empty | tx_push;

    i2c_target_responder_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
        .clk_i(clk_i), .rst_i(rst_i), .push_i(rx_push), .data_i(sh_q), .pop_i(rx_pop),
        .data_o(rx_data_o), .empty_o(rx_empty), .full_o(rx_full));

    i2c_target_responder_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
        .clk_i(clk_i), .rst_i(rst_i), .push_i(tx_push), .data_i(tx_data_i), .pop_i(tx_pop),
        .data_o(tx_dout), .empty_o(tx_empty), .full_o(tx_full));

    // Protocol engine
    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       oe_q, oe_d, ph_q, ph_d, rw_q, rw_d;
    logic       busy_q, busy_d, ovf_q, ovf_d, urf_q, urf_d;

    assign rd_byte   = tx_avail ? tx_dout : 8'hFF;
    assign addr_byte = {sh_q[6:0], sda_s2_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        oe_d    = oe_q;
        ph_d    = ph_q;
        rw_d    = rw_q;
        busy_d  = busy_q;
        ovf_d   = ovf_q;
        urf_d   = urf_q;
        rx_push = 1'b0;
        tx_pop  = 1'b0;
        if (start_det) begin
            state_d = S_ADDR;
            cnt_d   = 3'd0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (stop_det) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: if (scl_rise) begin
                    sh_d  = addr_byte;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        if (addr_byte[7:1] == ADDR) begin
                            state_d = S_ADDR_ACK;
                            busy_d  = 1'b1;
                            rw_d    = addr_byte[0];
                            ph_d    = 1'b0;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                end
                // ph_q: 0 before the ACK clock's low phase, 1 once ACK is on the bus.
                S_ADDR_ACK: if (scl_fall) begin
                    if (!ph_q) begin
                        oe_d = 1'b1;
                        ph_d = 1'b1;
                    end else if (rw_q) begin
                        state_d = S_RD_DATA;
                        cnt_d   = 3'd0;
                        tx_pop  = 1'b1;
                        urf_d   = urf_q | ~tx_avail;
                        sh_d    = rd_byte;
                        oe_d    = ~rd_byte[7];
                    end else begin
                        state_d = S_WR_DATA;
                        cnt_d   = 3'd0;
                        oe_d    = 1'b0;
                    end
                end
                S_WR_DATA: if (scl_rise) begin
                    sh_d  = addr_byte;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = S_WR_ACK;
                        ph_d    = 1'b0;
                    end
                end
                S_WR_ACK: if (scl_fall) begin
                    if (!ph_q) begin
                        ph_d = 1'b1;
                        if (!rx_full) begin
                            rx_push = 1'b1;
                            oe_d    = 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else begin
                        state_d = S_WR_DATA;
                        cnt_d   = 3'd0;
                        oe_d    = 1'b0;
                    end
                end
                // Bit 7 went out on entry; each later fall presents the next bit.
                S_RD_DATA: if (scl_fall) begin
                    if (cnt_q == 3'd7) begin
                        state_d = S_RD_ACK;
                        oe_d    = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        oe_d  = ~sh_q[6];
                        sh_d  = {sh_q[6:0], 1'b1};
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise && sda_s2_q) begin
                        state_d = S_IGNORE;
                    end else if (scl_fall) begin
                        state_d = S_RD_DATA;
                        cnt_d   = 3'd0;
                        tx_pop  = 1'b1;
                        urf_d   = urf_q | ~tx_avail;
                        sh_d    = rd_byte;
                        oe_d    = ~rd_byte[7];
                    end
                end
                default: oe_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            sh_q    <= 8'h00;
            oe_q    <= 1'b0;
            ph_q    <= 1'b0;
            rw_q    <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            urf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            oe_q    <= oe_d;
            ph_q    <= ph_d;
            rw_q    <= rw_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            urf_q   <= urf_d;
        end
    end

    assign sda_oe_o = oe_q;
    assign busy_o   = busy_q;
    assign ovf_o    = ovf_q;
    assign urf_o    = urf_q;
endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: a bit-banged I2C controller on an open-drain
// bus, with queues holding the bytes expected on RX and on bus reads.
module tb_i2c_target_responder;
    localparam int Q = 10;  // clk_i cycles per quarter SCL period

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       scl_m = 1'b1, sda_m = 1'b1;
    logic       scl_i, sda_i;
    logic       sda_oe_o, rx_valid_o, rx_ready_i = 1'b0;
    logic [7:0] rx_data_o, tx_data_i = 8'h00;
    logic       tx_valid_i = 1'b0, tx_ready_o, busy_o, ovf_o, urf_o;

    assign scl_i = scl_m;
    assign sda_i = sda_m & ~sda_oe_o;

    i2c_target_responder #(.ADDR(7'h22), .FIFO_DEPTH(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .scl_i(scl_i), .sda_i(sda_i), .sda_oe_o(sda_oe_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .busy_o(busy_o), .ovf_o(ovf_o), .urf_o(urf_o));

    always #5 clk_i = ~clk_i;

    int n_checks = 0, n_fail = 0;
    int oe_cnt = 0, hold_viol = 0, hi_cnt = 0;
    logic oe_prev = 1'b0;
    logic [7:0] rx_exp[$];
    logic [7:0] bus_exp[$];

    // Bus monitor: SDA must not move during the SCL-high phase.
    always @(negedge clk_i) begin
        if (scl_m) hi_cnt++;
        else hi_cnt = 0;
        if (hi_cnt > 4 && sda_oe_o !== oe_prev) hold_viol++;
        oe_prev = sda_oe_o;
        if (sda_oe_o) oe_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, want finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic bus_bit(input logic b, output logic r);
        sda_m = b;
        tick(Q); scl_m = 1'b1;
        tick(Q); r = sda_i;
        tick(Q); scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic bus_start();
        scl_m = 1'b0; tick(Q);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
        bus_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic rd_byte(input logic m_ack, output logic [7:0] b);
        logic r;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bus_bit(1'b1, r);
            b = {b[6:0], r};
        end
        bus_bit(~m_ack, r);
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_data_i = b; tx_valid_i = 1'b1;
        tick(1);
        tx_valid_i = 1'b0;
    endtask

    task automatic pop_rx(output logic [7:0] b, output logic got);
        got = rx_valid_o;
        b   = rx_data_o;
        if (got) begin
            rx_ready_i = 1'b1; tick(1); rx_ready_i = 1'b0;
        end else begin
            tick(1);
        end
    endtask

    task automatic test_reset();
        logic [6:0] flags;
        rst_i = 1'b1; tick(4);
        rst_i = 1'b0; tick(2);
        flags = {sda_oe_o, rx_valid_o, tx_ready_o, busy_o, ovf_o, urf_o, 1'b0};
        if (flags !== 7'b0010000) begin
            n_fail++; $display("FAIL reset_flags: got %b want %b", flags, 7'b0010000);
        end
        n_checks++;
        if (rx_data_o !== 8'h00) begin
            n_fail++; $display("FAIL reset_rx_data: got %h want 00", rx_data_o);
        end
        n_checks++;
    endtask

    task automatic test_write3();
        logic ack, got;
        logic [7:0] d, e;
        logic [7:0] data [3];
        data = '{8'hA5, 8'h00, 8'hFF};
        bus_start();
        wr_byte(8'h44, ack);
        if (ack !== 1'b1) begin n_fail++; $display("FAIL wr3_addr_ack: got %b want 1", ack); end
        n_checks++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL wr3_busy_hi: got %b want 1", busy_o); end
        n_checks++;
        for (int i = 0; i < 3; i++) begin
            wr_byte(data[i], ack);
            rx_exp.push_back(data[i]);
            if (ack !== 1'b1) begin n_fail++; $display("FAIL wr3_data_ack[%0d]: got %b want 1", i, ack); end
            n_checks++;
        end
        bus_stop(); tick(6);
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL wr3_busy_lo: got %b want 0", busy_o); end
        n_checks++;
        while (rx_exp.size() > 0) begin
            e = rx_exp.pop_front();
            pop_rx(d, got);
            if (got !== 1'b1 || d !== e) begin
                n_fail++; $display("FAIL wr3_rx: got %h (valid %b) want %h", d, got, e);
            end
            n_checks++;
        end
        if (rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL wr3_rx_empty: got %b want 0", rx_valid_o); end
        n_checks++;
    endtask

    task automatic test_read2();
        logic ack;
        logic [7:0] d, e;
        push_tx(8'h3C); bus_exp.push_back(8'h3C);
        push_tx(8'h81); bus_exp.push_back(8'h81);
        bus_start();
        wr_byte(8'h45, ack);
        if (ack !== 1'b1) begin n_fail++; $display("FAIL rd2_addr_ack: got %b want 1", ack); end
        n_checks++;
        for (int i = 0; i < 2; i++) begin
            rd_byte(i == 0, d);
            e = bus_exp.pop_front();
            if (d !== e) begin n_fail++; $display("FAIL rd2_byte[%0d]: got %h want %h", i, d, e); end
            n_checks++;
        end
        bus_stop(); tick(6);
        if ({urf_o, busy_o} !== 2'b00) begin
            n_fail++; $display("FAIL rd2_urf_busy: got %b want 00", {urf_o, busy_o});
        end
        n_checks++;
    endtask

    task automatic test_mismatch();
        logic ack;
        int c0;
        c0 = oe_cnt;
        bus_start();
        wr_byte(8'h46, ack);
        if (ack !== 1'b0) begin n_fail++; $display("FAIL mis_addr_ack: got %b want 0", ack); end
        n_checks++;
        wr_byte(8'h12, ack);
        if (ack !== 1'b0) begin n_fail++; $display("FAIL mis_data_ack: got %b want 0", ack); end
        n_checks++;
        bus_stop(); tick(6);
        if (oe_cnt !== c0) begin n_fail++; $display("FAIL mis_sda_oe: got %0d driven cycles want 0", oe_cnt - c0); end
        n_checks++;
        if ({rx_valid_o, busy_o} !== 2'b00) begin
            n_fail++; $display("FAIL mis_rx_busy: got %b want 00", {rx_valid_o, busy_o});
        end
        n_checks++;
    endtask

    task automatic test_overflow();
        logic ack, got;
        logic [7:0] v, d, e;
        bus_start();
        wr_byte(8'h44, ack);
        if (ack !== 1'b1) begin n_fail++; $display("FAIL ovf_addr_ack: got %b want 1", ack); end
        n_checks++;
        for (int i = 0; i < 9; i++) begin
            v = 8'(i * 29 + 7);
            wr_byte(v, ack);
            if (i < 8) rx_exp.push_back(v);
            if (ack !== (i < 8)) begin n_fail++; $display("FAIL ovf_ack[%0d]: got %b want %b", i, ack, i < 8); end
            n_checks++;
        end
        bus_stop(); tick(6);
        if (ovf_o !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", ovf_o); end
        n_checks++;
        while (rx_exp.size() > 0) begin
            e = rx_exp.pop_front();
            pop_rx(d, got);
            if (got !== 1'b1 || d !== e) begin
                n_fail++; $display("FAIL ovf_rx: got %h (valid %b) want %h", d, got, e);
            end
            n_checks++;
        end
        if (rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL ovf_rx_empty: got %b want 0", rx_valid_o); end
        n_checks++;
    endtask

    task automatic test_underflow_rs();
        logic ack, got;
        logic [7:0] d, e;
        bus_start();
        wr_byte(8'h44, ack);
        wr_byte(8'h01, ack);
        rx_exp.push_back(8'h01);
        if (ack !== 1'b1) begin n_fail++; $display("FAIL urf_wr_ack: got %b want 1", ack); end
        n_checks++;
        bus_start();
        wr_byte(8'h45, ack);
        if ({ack, busy_o} !== 2'b11) begin
            n_fail++; $display("FAIL urf_rs_ack_busy: got %b want 11", {ack, busy_o});
        end
        n_checks++;
        bus_exp.push_back(8'hFF);
        rd_byte(1'b0, d);
        e = bus_exp.pop_front();
        if (d !== e) begin n_fail++; $display("FAIL urf_byte: got %h want %h", d, e); end
        n_checks++;
        bus_stop(); tick(6);
        if (urf_o !== 1'b1) begin n_fail++; $display("FAIL urf_flag: got %b want 1", urf_o); end
        n_checks++;
        e = rx_exp.pop_front();
        pop_rx(d, got);
        if (got !== 1'b1 || d !== e) begin n_fail++; $display("FAIL urf_rx: got %h (valid %b) want %h", d, got, e); end
        n_checks++;
    endtask

    task automatic test_reset_mid_read();
        logic ack, r;
        int c0;
        push_tx(8'h00);
        bus_start();
        wr_byte(8'h45, ack);
        if (ack !== 1'b1) begin n_fail++; $display("FAIL rmr_addr_ack: got %b want 1", ack); end
        n_checks++;
        for (int i = 0; i < 4; i++) bus_bit(1'b1, r);
        // Bit 3 low phase: target is pulling SDA low when reset hits.
        sda_m = 1'b1; tick(Q);
        if (sda_oe_o !== 1'b1) begin n_fail++; $display("FAIL rmr_driving: got %b want 1", sda_oe_o); end
        n_checks++;
        rst_i = 1'b1; tick(1);
        if (sda_oe_o !== 1'b0) begin n_fail++; $display("FAIL rmr_release: got %b want 0", sda_oe_o); end
        n_checks++;
        rst_i = 1'b0;
        c0 = oe_cnt;
        tick(Q - 1); scl_m = 1'b1;
        tick(Q); scl_m = 1'b1;
        tick(Q); scl_m = 1'b0;
        tick(Q);
        for (int i = 0; i < 3; i++) bus_bit(1'b1, r);
        bus_bit(1'b0, r);
        wr_byte(8'h44, ack);
        if (ack !== 1'b0) begin n_fail++; $display("FAIL rmr_no_ack: got %b want 0", ack); end
        n_checks++;
        if (oe_cnt !== c0) begin n_fail++; $display("FAIL rmr_quiet: got %0d driven cycles want 0", oe_cnt - c0); end
        n_checks++;
        if ({ovf_o, urf_o, busy_o} !== 3'b000) begin
            n_fail++; $display("FAIL rmr_flags: got %b want 000", {ovf_o, urf_o, busy_o});
        end
        n_checks++;
        bus_start();
        wr_byte(8'h44, ack);
        if (ack !== 1'b1) begin n_fail++; $display("FAIL rmr_fresh_ack: got %b want 1", ack); end
        n_checks++;
        bus_stop(); tick(6);
    endtask

    task automatic test_tx_full();
        logic ack;
        logic [7:0] d, e;
        for (int i = 0; i < 8; i++) begin
            if (tx_ready_o !== 1'b1) begin n_fail++; $display("FAIL txf_ready[%0d]: got %b want 1", i, tx_ready_o); end
            n_checks++;
            push_tx(8'(8'hC0 + i));
            bus_exp.push_back(8'(8'hC0 + i));
        end
        if (tx_ready_o !== 1'b0) begin n_fail++; $display("FAIL txf_full: got %b want 0", tx_ready_o); end
        n_checks++;
        push_tx(8'h5A);  // refused while full
        bus_start();
        wr_byte(8'h45, ack);
        for (int i = 0; i < 8; i++) begin
            rd_byte(i < 7, d);
            e = bus_exp.pop_front();
            if (d !== e) begin n_fail++; $display("FAIL txf_byte[%0d]: got %h want %h", i, d, e); end
            n_checks++;
        end
        bus_stop(); tick(6);
        if ({tx_ready_o, urf_o} !== 2'b10) begin
            n_fail++; $display("FAIL txf_after: got %b want 10", {tx_ready_o, urf_o});
        end
        n_checks++;
    endtask

    initial begin
        test_reset();
        test_write3();
        test_read2();
        test_mismatch();
        test_overflow();
        test_underflow_rs();
        test_reset_mid_read();
        test_tx_full();
        if (hold_viol !== 0) begin
            n_fail++; $display("FAIL sda_hold: got %0d changes during SCL high want 0", hold_viol);
        end
        n_checks++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_target_responder.md
# i2c_target_responder

Synthesizable I2C target (slave) that sits on one I2C bus segment directly downstream of the i2cmb bus controller and answers its transactions. It decodes START/STOP, matches a 7-bit address, ACKs or NACKs, and moves data bytes between the bus and two byte FIFOs on the system side. This gives the controller a real RTL target for directed and random read/write traffic.

## Interface
- `ADDR`, 7'h22: 7-bit target address.
- `FIFO_DEPTH`, 8: entries in each of the RX and TX FIFOs; power of two, at least 2.
- `clk_i`  in  1: system clock; SCL/SDA are oversampled, and `clk_i` is at least 8x SCL.
- `rst_i`  in  1: synchronous, active-high reset.
- `scl_i`  in  1: bus SCL, asynchronous.
- `sda_i`  in  1: bus SDA, asynchronous.
- `sda_oe_o`  out  1: 1 pulls SDA low (open drain). Never drives high.
- `rx_data_o`  out  8: oldest received write byte.
- `rx_valid_o`  out  1: RX FIFO not empty.
- `rx_ready_i`  in  1: pop RX FIFO when `rx_valid_o` and `rx_ready_i`.
- `tx_data_i`  in  8: byte to return on bus reads.
- `tx_valid_i`  in  1: push TX FIFO when `tx_valid_i` and `tx_ready_o`.
- `tx_ready_o`  out  1: TX FIFO not full.
- `busy_o`  out  1: addressed transaction in progress, from address ACK until STOP or repeated START.
- `ovf_o`  out  1: sticky; a write byte was NACKed because RX was full. Cleared by reset only.
- `urf_o`  out  1: sticky; a read byte was sent from an empty TX FIFO. Cleared by reset only.

## Operation
- Input conditioning: `scl_i`/`sda_i` pass through a 2-FF synchronizer and a 1-FF history stage. Edges are detected on the synchronized signals.
- START or repeated START: synchronized SDA falls while SCL is high. From any state, go to ADDR and clear the bit counter.
- STOP: synchronized SDA rises while SCL is high. From any state, go to IDLE.
- Bits are sampled on the SCL rising edge, MSB first. SDA output changes only on the SCL falling edge.
- FSM states:
  - IDLE: `sda_oe_o`=0.
  - ADDR: shift 8 bits. On a match of bits [7:1] with `ADDR`, go to ADDR_ACK. Otherwise go to IGNORE.
  - ADDR_ACK: drive 0 for one SCL low/high period. The R/W bit selects WR_DATA (R/W=0) or RD_DATA (R/W=1).
  - WR_DATA: shift 8 bits, then go to WR_ACK.
  - WR_ACK: if RX is not full, push the byte and drive 0. If RX is full, release SDA (NACK) and set `ovf_o`. Then go to WR_DATA.
  - RD_DATA: on entry, pop TX. If TX is empty, send 8'hFF and set `urf_o`. Drive 0 bits only, for 8 bits, then go to RD_ACK.
  - RD_ACK: release SDA and sample the master bit. 0 (ACK) goes to RD_DATA; 1 (NACK) goes to IGNORE.
  - IGNORE: `sda_oe_o`=0. Wait for START or STOP.
- The RX/TX FIFOs are synchronous, first-word-fall-through, with a binary pointer plus one extra wrap bit. A simultaneous push and pop is allowed when full or empty: count is unchanged, and data order is preserved.
- Bus-side push/pop and system-side pop/push occur in the same cycle without conflict.

## Timing
- Reset values:
  - `sda_oe_o`=0, FSM=IDLE.
  - FIFOs empty: `rx_valid_o`=0, `tx_ready_o`=1, `rx_data_o`=0.
  - `busy_o`=0, `ovf_o`=0, `urf_o`=0.
  - Synchronizers are preset to 1 (idle bus).
- Reset asserted mid-transaction: `sda_oe_o`=0 on the next cycle. After reset, the block ignores the bus until the next START.
- Edge-to-action latency: 3 `clk_i` cycles from a pin edge to the registered state or `sda_oe_o` change.
- `sda_oe_o` changes within 3 cycles after the SCL fall. It is held through the whole SCL-high phase. This guarantees no SDA change while SCL is high.
- RX push timing: a pushed byte is visible on `rx_valid_o` one cycle after the WR_ACK decision.
- `tx_ready_o` timing: it deasserts the cycle after the push that makes the FIFO full.
- `busy_o` timing: rises with entry to ADDR_ACK on match, and falls with STOP detection.

## Test plan
- Write, 3 bytes: START, addr 0x44 (0x22<<1|0), data 0xA5, 0x00, 0xFF, STOP. Expect ACK on all 4 bytes, RX pops 0xA5, 0x00, 0xFF in order, `busy_o` 1 then 0.
- Read, 2 bytes: preload TX with 0x3C, 0x81. START, 0x45, master ACK then NACK, STOP. Expect bus bytes 0x3C, 0x81, TX empty, `urf_o`=0.
- Address mismatch: START, 0x46, write 0x12, STOP. Expect `sda_oe_o` to stay 0 throughout, RX empty, `busy_o`=0.
- RX overflow (FIFO_DEPTH=8): write 9 bytes with no pops. Expect bytes 1-8 ACKed, byte 9 NACKed, `ovf_o`=1, RX holds the first 8 bytes.
- TX underflow plus repeated START: write 0x01, then repeated START, 0x45, read 1 byte with TX empty. Expect 0xFF on the bus, `urf_o`=1, RX holds 0x01.
- Reset mid-read: assert `rst_i` while driving bit 3 of 0x00. Expect `sda_oe_o`=0 the next cycle, and no ACK on following bytes until a fresh START.
